// File: rtl/gpu_pkg.sv
// Shared types and limits for the GPU buffering blocks.
package gpu_pkg;

  typedef logic [7:0] warp_reg_t;

  localparam int MCB_MAX_CH = 16;

  // Index width for n items, never narrower than one bit.
  function automatic int chanWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last-served index.
module rr_arbiter
  import gpu_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = chanWidth(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] idxV;
  logic          found;
  int            idx;

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = 0;
    idxV   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N) idx = idx - N;
      idxV = IW'(idx);
      if (!found && req_i[idxV]) begin
        found       = 1'b1;
        gnt_o[idxV] = 1'b1;
        if (en_i) last_d = idxV;
      end
    end
  end

  // Start pointing at the top index so index 0 is served first after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= IW'(N - 1);
    else      last_q <= last_d;
  end

endmodule

// File: rtl/multi_circular_buffer.sv
// NUM_CH independent circular queues sharing one registered output port.
// Define MCB_RR_POP_EN to enable the round-robin pop_any path.
module multi_circular_buffer
  import gpu_pkg::*;
#(
  parameter type T         = warp_reg_t,
  parameter int  NUM_CH    = 4,
  parameter int  DEPTH     = 8,
  parameter int  AF_THRESH = DEPTH - 1,
  localparam int CW   = chanWidth(NUM_CH),
  localparam int PW   = $clog2(DEPTH),
  localparam int CNTW = $clog2(DEPTH + 1),
  localparam int DW   = $bits(T)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_buffer,
  input  logic [CW-1:0]          push_ch,
  input  logic [DW-1:0]          data_in,
  input  logic                   pop_buffer,
  input  logic                   read_buffer,
  input  logic [CW-1:0]          pop_ch,
  input  logic                   pop_any,
  output logic [DW-1:0]          data_out,
  output logic                   data_valid,
  output logic [CW-1:0]          out_ch,
  output logic [NUM_CH-1:0]      at_capacity,
  output logic [NUM_CH-1:0]      empty,
  output logic [NUM_CH-1:0]      almost_full,
  output logic [NUM_CH*CNTW-1:0] count,
  output logic                   overflow,
  output logic                   underflow
);

  T               mem_q   [NUM_CH][DEPTH];
  logic [PW-1:0]  head_q  [NUM_CH];
  logic [PW-1:0]  head_d  [NUM_CH];
  logic [PW-1:0]  tail_q  [NUM_CH];
  logic [PW-1:0]  tail_d  [NUM_CH];
  logic [CNTW-1:0] count_q [NUM_CH];
  logic [CNTW-1:0] count_d [NUM_CH];

  logic [DW-1:0] dataOut_q, dataOut_d;
  logic          dataValid_q, dataValid_d;
  logic [CW-1:0] outCh_q, outCh_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          rrMode;
  logic          rrAny;
  logic [CW-1:0] rrCh;

`ifdef MCB_RR_POP_EN
  logic [NUM_CH-1:0] notEmpty;
  logic [NUM_CH-1:0] rrGnt;

  always_comb begin
    notEmpty = '0;
    rrCh     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      notEmpty[i] = (count_q[i] != '0);
      if (rrGnt[i]) rrCh = CW'(i);
    end
  end

  rr_arbiter #(.N(NUM_CH)) u_rrArbiter (
    .clk   (clk),
    .rst   (rst),
    .req_i (notEmpty),
    .en_i  (pop_any),
    .gnt_o (rrGnt)
  );

  assign rrMode = pop_any;
  assign rrAny  = |notEmpty;
`else
  logic unusedPopAny;
  assign unusedPopAny = pop_any;
  assign rrMode       = 1'b0;
  assign rrAny        = 1'b0;
  assign rrCh         = '0;
`endif

  logic [CW-1:0] popCh;
  logic          popReq, popIsTake, popChOk, popHit, popTake;
  logic          pushChOk, pushHit, userReq;
  logic          inc, dec;

  // A pop frees a slot in the same cycle, so a full channel may accept a push alongside it.
  always_comb begin
    popCh     = rrMode ? rrCh : pop_ch;
    popReq    = rrMode ? rrAny : (pop_buffer | read_buffer);
    popIsTake = rrMode ? 1'b1 : pop_buffer;
    userReq   = !rrMode && (pop_buffer || read_buffer);
    popChOk   = int'(popCh) < NUM_CH;
    popHit    = popReq && popChOk && (count_q[popCh] != '0);
    popTake   = popHit && popIsTake;
    pushChOk  = int'(push_ch) < NUM_CH;
    pushHit   = push_buffer && pushChOk &&
                ((count_q[push_ch] != CNTW'(DEPTH)) || (popTake && (popCh == push_ch)));

    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      inc        = pushHit && (push_ch == CW'(i));
      dec        = popTake && (popCh == CW'(i));
      head_d[i]  = dec ? head_q[i] + 1'b1 : head_q[i];
      tail_d[i]  = inc ? tail_q[i] + 1'b1 : tail_q[i];
      count_d[i] = count_q[i] + {{(CNTW-1){1'b0}}, inc} - {{(CNTW-1){1'b0}}, dec};
    end

    dataOut_d   = popHit ? mem_q[popCh][head_q[popCh]] : dataOut_q;
    dataValid_d = popHit;
    outCh_d     = popHit ? popCh : outCh_q;
    overflow_d  = overflow_q | (push_buffer && pushChOk && !pushHit);
    underflow_d = underflow_q | (userReq && !popHit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      outCh_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
      dataOut_q   <= dataOut_d;
      dataValid_q <= dataValid_d;
      outCh_q     <= outCh_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (pushHit) mem_q[push_ch][tail_q[push_ch]] <= data_in;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      at_capacity[i]             = (count_q[i] == CNTW'(DEPTH));
      empty[i]                   = (count_q[i] == '0);
      almost_full[i]             = (count_q[i] >= CNTW'(AF_THRESH));
      count[i*CNTW +: CNTW]      = count_q[i];
    end
  end

  assign data_out   = dataOut_q;
  assign data_valid = dataValid_q;
  assign out_ch     = outCh_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
